i2c_config_sequencer: RTL and testbench

- Sequences the byte-level I2C write master that programs the HDMI transmitter registers at power-up and after every hot-plug event.
- Walks an external register ROM of {slave address, register address, data} entries and issues one I2C write per entry through a start/busy/done handshake.
- Handles ACK-failure retries, transaction timeouts and end-of-table markers, and reports done/error status to the overlay top level.

---
 rtl/i2c_config_sequencer.sv | 178 +++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// Walks a register ROM of {slave, register, data} entries and issues one I2C write per entry,
// with NACK/timeout retries, end-of-table markers and hot-plug triggered restarts.
module i2c_config_sequencer #(
    parameter int NUM_REGS       = 32,
    parameter int DELAY_CYCLES   = 1000000,
    parameter int RETRY_LIMIT    = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        configStart,
    input  logic        hotPlugDetect,
    output logic [7:0]  romAddress,
    input  logic [23:0] romData,
    output logic        i2cStart,
    output logic [7:0]  i2cSlaveAddress,
    output logic [7:0]  i2cRegAddress,
    output logic [7:0]  i2cWriteData,
    input  logic        i2cBusy,
    input  logic        i2cDone,
    input  logic        i2cAckError,
    output logic        configBusy,
    output logic        configDone,
    output logic        configError,
    output logic [7:0]  errorIndex
);

    localparam int DW = $clog2(DELAY_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CYCLES - 1);
    // Compare two below the limit so start-to-restart spacing equals TIMEOUT_CYCLES (ISSUE costs one cycle).
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]    IDX_LAST = 8'(NUM_REGS - 1);
    localparam logic [3:0]    RTY_LIM  = 4'(RETRY_LIMIT);

    typedef enum logic [2:0] {
        IDLE, WAIT_DELAY, FETCH, LATCH, ISSUE, WAIT_DONE, DONE, FAIL
    } state_t;

    state_t        state_q;
    logic [DW-1:0] dly_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    idx_q;
    logic [3:0]    retry_q;
    logic          pending_q;
    logic          hpd_s1_q, hpd_s2_q, hpd_prev_q;
    logic [7:0]    romAddress_q, slave_q, reg_q, data_q, errorIndex_q;
    logic          start_q, busy_q, done_q, error_q;

    logic hpd_rise, trigger, tmo_hit, resolved, failed, restart;

    assign hpd_rise = hpd_s2_q & ~hpd_prev_q;
    assign trigger  = configStart | hpd_rise;
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign resolved = i2cDone | tmo_hit;
    assign failed   = i2cDone ? i2cAckError : tmo_hit;

    always_comb begin
        restart = 1'b0;
        case (state_q)
            IDLE, DONE, FAIL:               restart = trigger;
            WAIT_DELAY, FETCH, LATCH, ISSUE: restart = hpd_rise;
            WAIT_DONE:                      restart = resolved & (pending_q | hpd_rise);
            default:                        restart = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            dly_q        <= '0;
            tmo_q        <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            pending_q    <= 1'b0;
            hpd_s1_q     <= 1'b0;
            hpd_s2_q     <= 1'b0;
            hpd_prev_q   <= 1'b0;
            romAddress_q <= '0;
            slave_q      <= '0;
            reg_q        <= '0;
            data_q       <= '0;
            errorIndex_q <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            hpd_s1_q   <= hotPlugDetect;
            hpd_s2_q   <= hpd_s1_q;
            hpd_prev_q <= hpd_s2_q;
            start_q    <= 1'b0;
            if (restart) begin
                state_q      <= WAIT_DELAY;
                dly_q        <= '0;
                idx_q        <= '0;
                retry_q      <= '0;
                pending_q    <= 1'b0;
                romAddress_q <= '0;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
                error_q      <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_DELAY: begin
                        if (dly_q == DLY_LAST) begin
                            state_q      <= FETCH;
                            romAddress_q <= idx_q;
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end
                    FETCH: state_q <= LATCH;
                    LATCH: begin
                        if (romData == 24'hFFFFFF) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            slave_q <= romData[23:16];
                            reg_q   <= romData[15:8];
                            data_q  <= romData[7:0];
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (!i2cBusy) begin
                            start_q <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (!resolved) begin
                            tmo_q <= tmo_q + 1'b1;
                            if (hpd_rise) pending_q <= 1'b1;
                        end else if (failed) begin
                            if (retry_q == RTY_LIM) begin
                                state_q      <= FAIL;
                                busy_q       <= 1'b0;
                                error_q      <= 1'b1;
                                errorIndex_q <= idx_q;
                            end else begin
                                retry_q <= retry_q + 1'b1;
                                state_q <= ISSUE;
                            end
                        end else begin
                            retry_q <= '0;
                            if (idx_q == IDX_LAST) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q        <= idx_q + 8'd1;
                                romAddress_q <= idx_q + 8'd1;
                                state_q      <= FETCH;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // A disconnected sink can never be considered configured.
            if (!hpd_s2_q) done_q <= 1'b0;
        end
    end

    assign romAddress      = romAddress_q;
    assign i2cStart        = start_q;
    assign i2cSlaveAddress = slave_q;
    assign i2cRegAddress   = reg_q;
    assign i2cWriteData    = data_q;
    assign configBusy      = busy_q;
    assign configDone      = done_q;
    assign configError     = error_q;
    assign errorIndex      = errorIndex_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer: ROM model, scripted I2C master responses, cycle-exact checks.
module tb_i2c_config_sequencer;

    localparam int NREG = 4;
    localparam int DLY  = 8;
    localparam int RTY  = 2;
    localparam int TMO  = 64;

    logic        clock;
    logic        reset;
    logic        configStart;
    logic        hotPlugDetect;
    logic [7:0]  romAddress;
    logic [23:0] romData;
    logic        i2cStart;
    logic [7:0]  i2cSlaveAddress;
    logic [7:0]  i2cRegAddress;
    logic [7:0]  i2cWriteData;
    logic        i2cBusy;
    logic        i2cDone;
    logic        i2cAckError;
    logic        configBusy;
    logic        configDone;
    logic        configError;
    logic [7:0]  errorIndex;

    i2c_config_sequencer #(
        .NUM_REGS(NREG), .DELAY_CYCLES(DLY), .RETRY_LIMIT(RTY), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .configStart(configStart), .hotPlugDetect(hotPlugDetect),
        .romAddress(romAddress), .romData(romData), .i2cStart(i2cStart),
        .i2cSlaveAddress(i2cSlaveAddress), .i2cRegAddress(i2cRegAddress),
        .i2cWriteData(i2cWriteData), .i2cBusy(i2cBusy), .i2cDone(i2cDone),
        .i2cAckError(i2cAckError), .configBusy(configBusy), .configDone(configDone),
        .configError(configError), .errorIndex(errorIndex)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [23:0] rom [0:255];
    logic [23:0] exp_e [0:3];

    // Master scoreboard: per-attempt response (0 ack, 1 nack, 2 no done) and start log.
    int          resp   [0:31];
    int          st_cyc [0:31];
    logic [23:0] st_val [0:31];
    int          nst;
    int          att;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    always_ff @(posedge clock) romData <= rom[romAddress];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int r;
        i2cBusy     = 1'b0;
        i2cDone     = 1'b0;
        i2cAckError = 1'b0;
        forever begin
            @(negedge clock);
            if (i2cStart === 1'b1) begin
                if (nst < 32) begin
                    st_cyc[nst] = cyc;
                    st_val[nst] = {i2cSlaveAddress, i2cRegAddress, i2cWriteData};
                end
                nst++;
                r = (att < 32) ? resp[att] : 0;
                att++;
                i2cBusy = 1'b1;
                repeat (19) @(negedge clock);
                i2cBusy = 1'b0;
                if (r != 2) begin
                    i2cDone     = 1'b1;
                    i2cAckError = (r == 1);
                    @(negedge clock);
                    i2cDone     = 1'b0;
                    i2cAckError = 1'b0;
                end
            end
        end
    end

    task automatic new_test(input int a0, input int a1, input int a2, input int a3, input int a4);
        for (int i = 0; i < 32; i++) resp[i] = 0;
        resp[0] = a0; resp[1] = a1; resp[2] = a2; resp[3] = a3; resp[4] = a4;
        nst = 0;
        att = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        repeat (3) @(negedge clock);
        while (configBusy === 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_val({tag, "_idle"}, {31'd0, configBusy}, 32'd0);
    endtask

    task automatic wait_nst(input string tag, input int k, input int budget);
        int n = 0;
        while (nst < k && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_val(tag, (nst >= k) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        configStart = 1'b1;
        @(negedge clock);
        configStart = 1'b0;
    endtask

    initial begin
        int t0;
        int n;
        exp_e[0] = 24'h724110;
        exp_e[1] = 24'h729803;
        exp_e[2] = 24'h72AF16;
        exp_e[3] = 24'h72D6C0;
        for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
        for (int i = 0; i < 4; i++) rom[i] = exp_e[i];
        new_test(0, 0, 0, 0, 0);
        reset = 1'b1;
        configStart = 1'b0;
        hotPlugDetect = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_busy", {31'd0, configBusy}, 32'd0);
        check_val("rst_done", {31'd0, configDone}, 32'd0);
        check_val("rst_err", {31'd0, configError}, 32'd0);
        check_val("rst_outs", {romAddress, i2cSlaveAddress, i2cRegAddress, i2cWriteData}, 32'd0);
        check_val("rst_start_eidx", {23'd0, i2cStart, errorIndex}, 32'd0);

        // HPD rising edge alone launches a pass.
        hotPlugDetect = 1'b1;
        repeat (5) @(negedge clock);
        check_val("hpd_trig_busy", {31'd0, configBusy}, 32'd1);
        wait_idle("warm", 2000);
        check_val("warm_done", {31'd0, configDone}, 32'd1);
        check_val("warm_nst", nst, 4);

        // 1: nominal pass, latency and ordering; a second configStart mid-pass is ignored.
        new_test(0, 0, 0, 0, 0);
        configStart = 1'b1;
        t0 = cyc;
        @(negedge clock);
        configStart = 1'b0;
        wait_nst("t1_first", 1, 200);
        pulse_start();
        wait_idle("t1", 2000);
        check_val("t1_latency", st_cyc[0] - t0, 12);
        check_val("t1_nst", nst, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("t1_val%0d", i), {8'd0, st_val[i]}, {8'd0, exp_e[i]});
        check_val("t1_flags", {29'd0, configDone, configBusy, configError}, 32'b100);

        // 2: two NACKs on entry 1, reissued straight from held registers.
        new_test(0, 1, 1, 0, 0);
        pulse_start();
        wait_idle("t2", 2000);
        check_val("t2_nst", nst, 6);
        for (int i = 1; i <= 3; i++) check_val($sformatf("t2_val%0d", i), {8'd0, st_val[i]}, {8'd0, exp_e[1]});
        check_val("t2_gap_a", st_cyc[2] - st_cyc[1], 21);
        check_val("t2_gap_b", st_cyc[3] - st_cyc[2], 21);
        check_val("t2_val4", {8'd0, st_val[4]}, {8'd0, exp_e[2]});
        check_val("t2_done", {31'd0, configDone}, 32'd1);

        // 3: entry 2 exhausts its retries.
        new_test(0, 0, 1, 1, 1);
        pulse_start();
        wait_idle("t3", 2000);
        repeat (40) @(negedge clock);
        check_val("t3_nst", nst, 5);
        check_val("t3_err", {31'd0, configError}, 32'd1);
        check_val("t3_eidx", {24'd0, errorIndex}, 32'd2);
        check_val("t3_done", {31'd0, configDone}, 32'd0);

        // 4: master never answers on entry 0.
        new_test(2, 2, 2, 2, 2);
        pulse_start();
        wait_idle("t4", 3000);
        repeat (80) @(negedge clock);
        check_val("t4_nst", nst, 3);
        check_val("t4_gap_a", st_cyc[1] - st_cyc[0], 64);
        check_val("t4_gap_b", st_cyc[2] - st_cyc[1], 64);
        check_val("t4_val2", {8'd0, st_val[2]}, {8'd0, exp_e[0]});
        check_val("t4_err", {23'd0, configError, errorIndex}, {23'd0, 1'b1, 8'd0});

        // 5: end marker at entry 1.
        rom[1] = 24'hFFFFFF;
        new_test(0, 0, 0, 0, 0);
        pulse_start();
        wait_idle("t5", 2000);
        check_val("t5_nst", nst, 1);
        check_val("t5_flags", {30'd0, configDone, configError}, 32'b10);
        rom[1] = exp_e[1];

        // 6: HPD re-plug during entry 2's write, then unplug after completion.
        new_test(0, 0, 0, 0, 0);
        pulse_start();
        wait_nst("t6_e2", 3, 500);
        hotPlugDetect = 1'b0;
        repeat (4) @(negedge clock);
        hotPlugDetect = 1'b1;
        n = 0;
        while (cyc < st_cyc[2] + 22 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_val("t6_romaddr", {24'd0, romAddress}, 32'd0);
        check_val("t6_busy", {31'd0, configBusy}, 32'd1);
        wait_idle("t6", 2000);
        check_val("t6_nst", nst, 7);
        check_val("t6_restart_val", {8'd0, st_val[3]}, {8'd0, exp_e[0]});
        check_val("t6_restart_gap", st_cyc[3] - st_cyc[2], 31);
        check_val("t6_done", {31'd0, configDone}, 32'd1);
        hotPlugDetect = 1'b0;
        repeat (3) @(negedge clock);
        check_val("t6_unplug", {31'd0, configDone}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
